// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-through, no-write-allocate data-cache controller.
// It serves one CPU load/store at a time. Cacheable loads look up the cache
// and fill it on a miss. Uncached loads (addr[31:29]==3'b101) go straight to
// memory. Stores go to memory. A cacheable store also updates the cache line
// on a full-word write, or invalidates the line on a partial write.
//
// Ports:
//   clk, resetn                           clock, synchronous active-low reset
//   req/wr/addr/wdata/wstrb               CPU request (accepted on req & addr_ok)
//   addr_ok, data_ok, rdata               CPU handshake and load data
//   c_raddr/c_rdata/c_hit                 cache lookup
//   c_wen/c_clear/c_waddr/c_wdata         cache fill, update and invalidate
//   mem_req/mem_wr/mem_addr/mem_wdata/mem_wstrb, mem_addr_ok/mem_data_ok/mem_rdata
//                                         memory request and response
//   hit_cnt, miss_cnt                     counters, present only with DCACHE_PERF_CNT_EN
//
// Optional feature macro: DCACHE_PERF_CNT_EN (hit and miss-fill counters).
module dcache_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic [29:0] c_raddr,
    input  logic [31:0] c_rdata,
    input  logic        c_hit,
    output logic        c_wen,
    output logic        c_clear,
    output logic [29:0] c_waddr,
    output logic [31:0] c_wdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned DW  = 32;
    localparam int unsigned WAW = 30;
    localparam int unsigned SW  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_WR_REQ,
        S_WR_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WAW-1:0]  r_addr;
    logic            r_uncached;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_wstrb;
    logic [DW-1:0]   r_rdata;
    logic            w_accept;
    logic            w_in_uncached;
    logic            w_hit;
    logic            w_fill;
    logic            w_unused_ok;

    // Byte-offset bits never affect a word access.
    assign w_unused_ok   = &{1'b0, addr[1:0]};
    assign w_in_uncached = (addr[31:29] == 3'b101);
    assign w_accept      = req & addr_ok;

    // State and latched request; the request register clears on reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_uncached <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr     <= addr[31:2];
                r_uncached <= w_in_uncached;
                r_wdata    <= wr ? wdata : '0;
                r_wstrb    <= wr ? wstrb : '0;
            end
            if (data_ok) begin
                r_rdata <= rdata;
            end
        end
    end

    // Next state and outputs. Everything is held at 0 while resetn is low,
    // so a transaction cut off by reset never signals completion.
    always_comb begin
        w_next    = r_state;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = r_rdata;
        c_raddr   = '0;
        c_wen     = 1'b0;
        c_clear   = 1'b0;
        c_waddr   = '0;
        c_wdata   = '0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        w_hit     = 1'b0;
        w_fill    = 1'b0;
        if (resetn) begin
            if (r_state != S_IDLE) begin
                c_raddr = r_addr;
            end
            case (r_state)
                S_IDLE: begin
                    addr_ok = 1'b1;
                    if (req) begin
                        if (wr)                 w_next = S_WR_REQ;
                        else if (w_in_uncached) w_next = S_MISS_REQ;
                        else                    w_next = S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (c_hit) begin
                        data_ok = 1'b1;
                        rdata   = c_rdata;
                        w_hit   = 1'b1;
                        w_next  = S_IDLE;
                    end else begin
                        w_next  = S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    mem_req  = 1'b1;
                    mem_addr = {r_addr, 2'b00};
                    if (mem_addr_ok) w_next = S_MISS_WAIT;
                end
                S_MISS_WAIT: begin
                    if (mem_data_ok) begin
                        data_ok = 1'b1;
                        rdata   = mem_rdata;
                        if (!r_uncached) begin
                            c_wen   = 1'b1;
                            c_waddr = r_addr;
                            c_wdata = mem_rdata;
                            w_fill  = 1'b1;
                        end
                        w_next = S_IDLE;
                    end
                end
                S_WR_REQ: begin
                    mem_req   = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = {r_addr, 2'b00};
                    mem_wdata = r_wdata;
                    mem_wstrb = r_wstrb;
                    // Update or invalidate the cached copy exactly once, at the memory handshake.
                    if (mem_addr_ok) begin
                        if (!r_uncached) begin
                            c_waddr = r_addr;
                            if (r_wstrb == 4'hF) begin
                                c_wen   = 1'b1;
                                c_wdata = r_wdata;
                            end else begin
                                c_clear = 1'b1;
                            end
                        end
                        w_next = S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (mem_data_ok) begin
                        data_ok = 1'b1;
                        w_next  = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // Hit and miss-fill counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (w_hit)  hit_cnt  <= hit_cnt + 32'(1);
            if (w_fill) miss_cnt <= miss_cnt + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed, self-checking bench for dcache_ctrl.
// Inputs change on the falling edge. Outputs are sampled 1 ns later, so no
// sample ever lands on the rising edge.
module tb_dcache_ctrl;

    logic        clk;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic [29:0] c_raddr;
    logic [31:0] c_rdata;
    logic        c_hit;
    logic        c_wen;
    logic        c_clear;
    logic [29:0] c_waddr;
    logic [31:0] c_wdata;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_total;
    int n_bad;

    dcache_ctrl u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .wr          (wr),
        .addr        (addr),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .addr_ok     (addr_ok),
        .data_ok     (data_ok),
        .rdata       (rdata),
        .c_raddr     (c_raddr),
        .c_rdata     (c_rdata),
        .c_hit       (c_hit),
        .c_wen       (c_wen),
        .c_clear     (c_clear),
        .c_waddr     (c_waddr),
        .c_wdata     (c_wdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Let combinational outputs settle after inputs change.
    task automatic settle();
        #1;
    endtask

    // Present a request in IDLE and check that it is accepted.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input string tag);
        cyc();
        req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
        settle();
        chk({tag, "_addr_ok"}, 32'(addr_ok), 32'd1);
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        c_rdata = '0; c_hit = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

        // Reset state
        cyc(); cyc(); settle();
        chk("rst_addr_ok", 32'(addr_ok), 32'd0);
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_rdata",   rdata,        32'h0);
        cyc(); resetn = 1'b1; settle();
        chk("post_rst_addr_ok", 32'(addr_ok), 32'd1);

        // A stray mem_data_ok in IDLE must not complete anything.
        mem_data_ok = 1'b1; settle();
        chk("idle_stray_data_ok", 32'(data_ok), 32'd0);
        mem_data_ok = 1'b0;

        // Cacheable load miss with fill
        issue(1'b0, 32'h8000_1004, 32'h0, 4'h0, "ld_miss");
        cyc(); req = 1'b0; c_hit = 1'b0; settle();               // LOOKUP
        chk("lookup_c_raddr", 32'(c_raddr), 32'h2000_0401);
        chk("lookup_data_ok", 32'(data_ok), 32'd0);
        chk("lookup_mem_req", 32'(mem_req), 32'd0);
        cyc(); settle();                                         // MISS_REQ, stalled
        chk("miss_req_stall", 32'(mem_req), 32'd1);
        cyc(); mem_addr_ok = 1'b1; settle();                     // MISS_REQ, accepted
        chk("miss_req_hold",  32'(mem_req), 32'd1);
        chk("miss_mem_addr",  mem_addr,     32'h8000_1004);
        chk("miss_mem_wr",    32'(mem_wr),  32'd0);
        chk("miss_mem_wstrb", 32'(mem_wstrb), 32'd0);
        cyc(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678; settle();
        chk("fill_data_ok", 32'(data_ok), 32'd1);
        chk("fill_rdata",   rdata,        32'h1234_5678);
        chk("fill_c_wen",   32'(c_wen),   32'd1);
        chk("fill_c_waddr", 32'(c_waddr), 32'h2000_0401);
        chk("fill_c_wdata", c_wdata,      32'h1234_5678);
        cyc(); mem_data_ok = 1'b0; mem_rdata = 32'hDEAD_0000; settle();
        chk("after_fill_data_ok", 32'(data_ok), 32'd0);
        chk("after_fill_rdata",   rdata,        32'h1234_5678);

        // Cacheable load hit: data_ok one cycle after accept, no memory traffic
        issue(1'b0, 32'h8000_1004, 32'h0, 4'h0, "ld_hit");
        cyc(); req = 1'b0; c_hit = 1'b1; c_rdata = 32'h1234_5678; settle();
        chk("hit_data_ok", 32'(data_ok), 32'd1);
        chk("hit_rdata",   rdata,        32'h1234_5678);
        chk("hit_mem_req", 32'(mem_req), 32'd0);
        cyc(); c_hit = 1'b0; c_rdata = 32'h0; settle();
        chk("hit_back_idle", 32'(addr_ok), 32'd1);
`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt_1",  hit_cnt,  32'd1);
        chk("miss_cnt_1", miss_cnt, 32'd1);
`endif

        // Full-word cacheable store updates the line at the memory handshake.
        issue(1'b1, 32'h8000_1004, 32'hCAFE_BABE, 4'hF, "st_full");
        cyc(); req = 1'b0; mem_addr_ok = 1'b1; settle();
        chk("stf_mem_req",   32'(mem_req),   32'd1);
        chk("stf_mem_wr",    32'(mem_wr),    32'd1);
        chk("stf_mem_wdata", mem_wdata,      32'hCAFE_BABE);
        chk("stf_mem_wstrb", 32'(mem_wstrb), 32'hF);
        chk("stf_c_wen",     32'(c_wen),     32'd1);
        chk("stf_c_clear",   32'(c_clear),   32'd0);
        chk("stf_c_waddr",   32'(c_waddr),   32'h2000_0401);
        chk("stf_c_wdata",   c_wdata,        32'hCAFE_BABE);
        cyc(); mem_addr_ok = 1'b0; settle();                     // WR_WAIT
        chk("stf_wait_c_wen",   32'(c_wen),   32'd0);
        chk("stf_wait_data_ok", 32'(data_ok), 32'd0);
        cyc(); mem_data_ok = 1'b1; settle();
        chk("stf_done", 32'(data_ok), 32'd1);
        cyc(); mem_data_ok = 1'b0;

        // Partial cacheable store invalidates the line instead of writing it.
        issue(1'b1, 32'h8000_1004, 32'h0000_BEEF, 4'h3, "st_part");
        cyc(); req = 1'b0; mem_addr_ok = 1'b1; settle();
        chk("stp_mem_wstrb", 32'(mem_wstrb), 32'h3);
        chk("stp_c_clear",   32'(c_clear),   32'd1);
        chk("stp_c_wen",     32'(c_wen),     32'd0);
        cyc(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; settle();
        chk("stp_done", 32'(data_ok), 32'd1);
        chk("stp_done_c_clear", 32'(c_clear), 32'd0);
        cyc(); mem_data_ok = 1'b0;

        // An uncached store touches neither c_wen nor c_clear.
        issue(1'b1, 32'hA000_0010, 32'h5555_AAAA, 4'hF, "st_unc");
        cyc(); req = 1'b0; mem_addr_ok = 1'b1; settle();
        chk("stu_mem_addr", mem_addr,       32'hA000_0010);
        chk("stu_c_wen",    32'(c_wen),     32'd0);
        chk("stu_c_clear",  32'(c_clear),   32'd0);
        cyc(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; settle();
        chk("stu_done", 32'(data_ok), 32'd1);
        cyc(); mem_data_ok = 1'b0;

        // An uncached load skips the lookup and never fills the cache.
        issue(1'b0, 32'hBFC0_0000, 32'h0, 4'h0, "ld_unc");
        cyc(); req = 1'b0; mem_addr_ok = 1'b1; settle();         // MISS_REQ directly
        chk("ldu_mem_req",  32'(mem_req), 32'd1);
        chk("ldu_mem_addr", mem_addr,     32'hBFC0_0000);
        cyc(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_0001; settle();
        chk("ldu_data_ok", 32'(data_ok), 32'd1);
        chk("ldu_rdata",   rdata,        32'h3C1D_0001);
        chk("ldu_c_wen",   32'(c_wen),   32'd0);
        cyc(); mem_data_ok = 1'b0; settle();
`ifdef DCACHE_PERF_CNT_EN
        chk("ldu_hit_cnt",  hit_cnt,  32'd1);
        chk("ldu_miss_cnt", miss_cnt, 32'd1);
`endif

        // A request held during MISS_WAIT is not accepted; reset abandons the miss.
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h0, "ld_rst");
        cyc(); c_hit = 1'b0; settle();                           // LOOKUP, req held
        chk("busy_addr_ok_lookup", 32'(addr_ok), 32'd0);
        cyc(); mem_addr_ok = 1'b1; settle();                     // MISS_REQ
        chk("busy_mem_addr", mem_addr, 32'h0000_0100);
        cyc(); mem_addr_ok = 1'b0; settle();                     // MISS_WAIT
        chk("busy_addr_ok_wait", 32'(addr_ok), 32'd0);
        cyc(); resetn = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777; settle();
        chk("rst_wait_data_ok", 32'(data_ok), 32'd0);
        chk("rst_wait_c_wen",   32'(c_wen),   32'd0);
        cyc(); resetn = 1'b1; req = 1'b0; mem_data_ok = 1'b0; settle();
        chk("rst_wait_idle",    32'(addr_ok), 32'd1);
        chk("rst_wait_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wait_rdata",   rdata,        32'h0);
`ifdef DCACHE_PERF_CNT_EN
        chk("rst_hit_cnt",  hit_cnt,  32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif

        cyc();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
